uart_tx: RTL and testbench
==========================

# uart_tx

Byte-serial UART transmitter, 8N1, LSB first, with a small input FIFO. It is the transmit companion to the design's UART receiver: the same clock and baud parameters, on the FPGA's `UART_TX_o` pin. Upstream logic, such as SRAM readback or echo paths, pushes bytes through a valid/ready handshake. The block serialises them back-to-back with no idle gap while bytes remain queued.

## Interface
Parameters:
- `CLK_FREQ`, default 12_000_000: input clock frequency in Hz.
- `BAUD`, default 115_200: line rate.
- `FIFO_DEPTH`, default 4: input FIFO entries; must be a power of 2, ≥ 2.
- Derived `BIT_CYCLES` = `CLK_FREQ / BAUD`, integer truncation (104 at defaults).

Ports:
- `CLK_IN`  in  1  system clock; single clock domain.
- `RST_IN`  in  1  asynchronous, active-high reset.
- `DATA_i`  in  8  byte to transmit.
- `VALID_i`  in  1  `DATA_i` is valid.
- `READY_o`  out  1  FIFO can accept a byte; equals `!full`.
- `UART_TX_o`  out  1  serial line, idle high, registered.
- `BUSY_o`  out  1  high while a frame is on the line or the FIFO is non-empty.
- `LEVEL_o`  out  clog2(`FIFO_DEPTH`)+1  current FIFO occupancy.

## Operation
- **Handshake:** a byte is accepted on a rising edge where `VALID_i && READY_o`. `READY_o` is combinational from the registered FIFO count only, never from `VALID_i`. While `READY_o` is low, `DATA_i` is ignored and the upstream holds.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE: line is 1. If the FIFO is non-empty, pop into the 8-bit shift register, clear the bit counter, and go to START.
  - START: line is 0 for `BIT_CYCLES`, then go to DATA.
  - DATA: line is `shift[0]` for `BIT_CYCLES` per bit. Shift right after each bit. After bit 7, go to STOP.
  - STOP: line is 1 for `BIT_CYCLES`. On the last cycle of STOP:
    - FIFO non-empty: pop and go directly to START, giving back-to-back frames.
    - FIFO empty: go to IDLE.
- **Counters:** a baud counter runs from 0 to `BIT_CYCLES`−1 and wraps to 0 at each bit boundary. A 3-bit bit index wraps after 7.
- **FIFO:** circular buffer with wrap-around read/write pointers. Simultaneous push and pop leaves the count unchanged.
  - When full, `READY_o` = 0. A same-cycle pop does not admit a push in that cycle; `READY_o` rises on the next cycle.
  - Popping while empty never occurs; the FSM checks non-empty first.
- **Reset:** asserting `RST_IN` at any time forces IDLE and empties the FIFO. Any frame in flight is aborted and lost, and the line goes high immediately with no partial-frame continuation.

## Timing
- **Reset values:**
  - `UART_TX_o` = 1
  - `READY_o` = 1
  - `BUSY_o` = 0
  - `LEVEL_o` = 0
  - FSM = IDLE, all counters 0.
- **Latency:** a byte pushed at edge N into an empty FIFO with the FSM in IDLE:
  - Edge N+1: the FSM pops and `UART_TX_o` falls.
  - Edge N+1+10·`BIT_CYCLES`: the frame ends, with the line high.
- **Frame length:** exactly 10·`BIT_CYCLES` cycles (1040 at defaults). Every bit, including the stop bit, is exactly `BIT_CYCLES` cycles.
- **Back-to-back frames:** the start bit of the next frame begins the cycle after the last stop-bit cycle, with zero gap.
- **`LEVEL_o`:** updates on the edge after a push or pop. It counts FIFO entries only; the shift register is excluded.
- **`BUSY_o`:** rises on the edge after the first accepted push. It falls on the edge the FSM enters IDLE with the FIFO empty.

## Structure
- **Shared include `uart_defs.vh`:**
  - `UART_DATA_BITS` = 8
  - FSM state encodings: IDLE=0, START=1, DATA=2, STOP=3
  - `UART_BIT_CYCLES(clk, baud)` macro
  - Reused by the existing receiver so both ends agree on the divider.
- **Sub-module `sync_fifo`:**
  - Parameters: `WIDTH`, `DEPTH`.
  - Ports: push/pop, full/empty, level.
  - Same clock and asynchronous reset as `uart_tx`.
- **`uart_tx` itself:** FSM, baud counter, bit counter, shift register, output register.

## Test plan
- **Single byte:** reset, then push 0xAA once. Expect the line to fall one cycle later, then carry 0,0,1,0,1,0,1,0,1,1, each held 104 cycles. `BUSY_o` is low 1040 cycles after the start bit.
- **Back-to-back:** push 0x55 then 0x0F on consecutive cycles. Expect 20 contiguous bit periods with no idle cycle between the stop bit of 0x55 and the start bit of 0x0F. Bit order is LSB first.
- **FIFO full:** hold `VALID_i` high with 6 distinct bytes.
  - The first byte is popped into the shift register, and the next 4 are accepted.
  - `READY_o` drops with `LEVEL_o` = 4.
  - The 6th byte is accepted one cycle after the first frame's final pop.
  - All 6 are transmitted in order.
- **Reset mid-frame:** assert `RST_IN` during bit 3 of 0xC3 with 2 bytes queued. Expect:
  - `UART_TX_o` = 1 asynchronously
  - `LEVEL_o` = 0, `BUSY_o` = 0
  - no further frames after release.
- **Loopback:** wire `UART_TX_o` to the existing receiver's `UART_RX_i` and send 0x00, 0xFF, 0xA5. The receiver must recover the identical bytes in order.
- **Handshake stall:** `VALID_i` held low with the FIFO empty. Expect the line to stay high indefinitely and `READY_o` = 1.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: data width, FSM encodings and the baud divider helper.
// The receiver imports the same package so both ends agree on the divider.
package uart_tx_pkg;
    localparam int UART_DATA_BITS = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    function automatic int uart_bit_cycles(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction
endpackage

// File: rtl/uart_tx_sync_fifo.sv
// Single-clock circular FIFO with occupancy count; power-of-two depth so pointers wrap freely.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             do_push_s, do_pop_s;

    // A push is refused while full even if a pop happens in the same cycle.
    assign do_push_s = push_i && !full_o;
    assign do_pop_s  = pop_i && !empty_o;
    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign empty_o   = (count_q == (AW+1)'(0));
    assign level_o   = count_q;
    assign rdata_o   = mem_q[rd_ptr_q];

    // Occupancy next-state.
    always_comb begin
        count_d = count_q;
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= AW'(0);
            rd_ptr_q <= AW'(0);
            count_q  <= (AW+1)'(0);
        end else begin
            if (do_push_s) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    // Storage array.
    always_ff @(posedge clk_i) begin
        if (do_push_s) mem_q[wr_ptr_q] <= wdata_i;
    end
endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, fed through a small FIFO; frames go out back-to-back
// while bytes remain queued.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int CLK_FREQ   = 12_000_000,
    parameter int BAUD       = 115_200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          CLK_IN,
    input  logic                          RST_IN,
    input  logic [7:0]                    DATA_i,
    input  logic                          VALID_i,
    output logic                          READY_o,
    output logic                          UART_TX_o,
    output logic                          BUSY_o,
    output logic [$clog2(FIFO_DEPTH):0]   LEVEL_o
);
    localparam int BIT_CYCLES = uart_bit_cycles(CLK_FREQ, BAUD);
    localparam int CNT_W      = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BIT_CYCLES - 1);

    logic [1:0]                state_q, state_d;
    logic [CNT_W-1:0]          baud_q, baud_d;
    logic [2:0]                bit_q, bit_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      tx_q, tx_d;
    logic                      pop_s, baud_last_s;
    logic [UART_DATA_BITS-1:0] fifo_rdata_s;
    logic                      fifo_full_s, fifo_empty_s;

    sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (CLK_IN),
        .rst_i   (RST_IN),
        .push_i  (VALID_i),
        .wdata_i (DATA_i),
        .pop_i   (pop_s),
        .rdata_o (fifo_rdata_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .level_o (LEVEL_o)
    );

    assign READY_o     = !fifo_full_s;
    assign UART_TX_o   = tx_q;
    assign BUSY_o      = (state_q != ST_IDLE) || !fifo_empty_s;
    assign baud_last_s = (baud_q == BAUD_LAST);

    // Frame sequencer; the line value for the next bit is computed at each bit boundary.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                baud_d = CNT_W'(0);
                if (!fifo_empty_s) begin
                    pop_s   = 1'b1;
                    shift_d = fifo_rdata_s;
                    bit_d   = 3'd0;
                    tx_d    = 1'b0;
                    state_d = ST_START;
                end else begin
                    tx_d    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_last_s) begin
                    baud_d  = CNT_W'(0);
                    tx_d    = shift_q[0];
                    state_d = ST_DATA;
                end else begin
                    baud_d  = baud_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (baud_last_s) begin
                    baud_d = CNT_W'(0);
                    bit_d  = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        shift_d = {1'b0, shift_q[UART_DATA_BITS-1:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (baud_last_s) begin
                    baud_d = CNT_W'(0);
                    if (!fifo_empty_s) begin
                        pop_s   = 1'b1;
                        shift_d = fifo_rdata_s;
                        bit_d   = 3'd0;
                        tx_d    = 1'b0;
                        state_d = ST_START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            default: begin
                baud_d  = CNT_W'(0);
                tx_d    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state and registered line output; reset drives the line high at once.
    always_ff @(posedge CLK_IN or posedge RST_IN) begin
        if (RST_IN) begin
            state_q <= ST_IDLE;
            baud_q  <= CNT_W'(0);
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: table of bytes with hand-written line patterns,
// a scoreboard fed on handshake and drained by a line monitor.
module tb_uart_tx;
    localparam int B     = 104;
    localparam int FRAME = 10 * B;

    typedef struct {
        logic [7:0] data;
        logic [9:0] bits;   // bit 0 = start bit, bit 9 = stop bit
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] data = 8'h00;
    logic       valid = 1'b0;
    logic       ready, tx, busy;
    logic [2:0] level;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    vec_t       tbl [15];
    int         acc [15];
    int         stall_cnt;
    int         stall_level;
    logic [9:0] sb [$];
    int         starts [$];

    uart_tx dut (
        .CLK_IN    (clk),
        .RST_IN    (rst),
        .DATA_i    (data),
        .VALID_i   (valid),
        .READY_o   (ready),
        .UART_TX_o (tx),
        .BUSY_o    (busy),
        .LEVEL_o   (level)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Present table entries lo..hi in order, holding each until accepted; called at a negedge.
    task automatic push_range(input int lo, input int hi, input bit to_sb);
        stall_cnt   = 0;
        stall_level = -1;
        for (int i = lo; i <= hi; i++) begin
            bit rdy;
            bit ok;
            int w;
            data  = tbl[i].data;
            valid = 1'b1;
            ok    = 1'b0;
            w     = 0;
            while (!ok && w < 5000) begin
                rdy = ready;
                if (!rdy) begin
                    stall_cnt++;
                    stall_level = int'(level);
                end
                @(posedge clk);
                if (rdy) ok = 1'b1;
                else w++;
                @(negedge clk);
            end
            chk("accepted", ok, 1);
            acc[i] = cyc;
            if (ok && to_sb) sb.push_back(tbl[i].bits);
        end
        valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int w = 0;
        while (busy !== 1'b0 && w < 20000) begin
            @(negedge clk);
            w++;
        end
        chk({name, "_idle"}, busy, 0);
        repeat (2) @(negedge clk);
    endtask

    // Line monitor: captures whole frames, checks every bit is held B cycles, compares with scoreboard.
    initial begin
        logic [9:0] got;
        logic [9:0] e;
        logic       v;
        bit         stable;
        int         s;
        v = 1'b1;
        forever begin
            @(negedge clk);
            if (mon_en && tx === 1'b0) begin
                s      = cyc;
                stable = 1'b1;
                for (int k = 0; k < 10; k++) begin
                    for (int c = 0; c < B; c++) begin
                        if (k != 0 || c != 0) @(negedge clk);
                        if (c == 0) v = tx;
                        else if (tx !== v) stable = 1'b0;
                    end
                    got[k] = v;
                end
                starts.push_back(s);
                chk("bit_hold", stable, 1);
                e = (sb.size() > 0) ? sb.pop_front() : 10'bx;
                chk("frame", got, e);
            end
        end
    end

    initial begin
        int a;
        int bad;
        tbl[0]  = '{8'hAA, 10'b1_1010_1010_0};
        tbl[1]  = '{8'h55, 10'b1_0101_0101_0};
        tbl[2]  = '{8'h0F, 10'b1_0000_1111_0};
        tbl[3]  = '{8'h00, 10'b1_0000_0000_0};
        tbl[4]  = '{8'hFF, 10'b1_1111_1111_0};
        tbl[5]  = '{8'hA5, 10'b1_1010_0101_0};
        tbl[6]  = '{8'h11, 10'b1_0001_0001_0};
        tbl[7]  = '{8'h22, 10'b1_0010_0010_0};
        tbl[8]  = '{8'h33, 10'b1_0011_0011_0};
        tbl[9]  = '{8'h44, 10'b1_0100_0100_0};
        tbl[10] = '{8'h66, 10'b1_0110_0110_0};
        tbl[11] = '{8'h77, 10'b1_0111_0111_0};
        tbl[12] = '{8'hC3, 10'b1_1100_0011_0};
        tbl[13] = '{8'h5A, 10'b1_0101_1010_0};
        tbl[14] = '{8'h3C, 10'b1_0011_1100_0};

        // Reset values
        #2 rst = 1'b1;
        #1;
        chk("rst_tx", tx, 1);
        chk("rst_ready", ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_level", level, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Handshake stall: nothing offered, line stays idle
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx !== 1'b1 || ready !== 1'b1) bad++;
        end
        chk("stall_idle", bad, 0);
        mon_en = 1'b1;

        // Single byte: latency and busy window
        push_range(0, 0, 1'b1);
        a = acc[0];
        chk("single_tx_pre", tx, 1);
        chk("single_level1", level, 1);
        chk("single_busy_rise", busy, 1);
        @(negedge clk);
        chk("single_tx_fall", tx, 0);
        chk("single_level0", level, 0);
        wait_cyc(a + FRAME);
        chk("single_busy_last", busy, 1);
        chk("single_stop_high", tx, 1);
        @(negedge clk);
        chk("single_busy_fall", busy, 0);
        chk("single_tx_idle", tx, 1);
        @(negedge clk);
        chk("single_nstarts", starts.size(), 1);
        if (starts.size() > 0) chk("single_start_cyc", starts[0], a + 1);
        starts.delete();

        // Back-to-back pair
        push_range(1, 2, 1'b1);
        chk("b2b_consec_accept", acc[2] - acc[1], 1);
        wait_idle("b2b");
        chk("b2b_nstarts", starts.size(), 2);
        if (starts.size() == 2) begin
            chk("b2b_first_start", starts[0], acc[1] + 1);
            chk("b2b_no_gap", starts[1] - starts[0], FRAME);
        end
        starts.delete();

        // Loopback-style recovery of extreme patterns
        push_range(3, 5, 1'b1);
        wait_idle("loop");
        chk("loop_sb_empty", sb.size(), 0);
        starts.delete();

        // FIFO full with VALID held high
        push_range(6, 11, 1'b1);
        chk("full_accept_4", acc[10] - acc[6], 4);
        chk("full_accept_6th", acc[11] - acc[6], FRAME + 2);
        chk("full_stall_level", stall_level, 4);
        chk("full_stall_cycles", stall_cnt, FRAME - 3);
        wait_idle("full");
        chk("full_sb_empty", sb.size(), 0);
        chk("full_nstarts", starts.size(), 6);
        if (starts.size() == 6) chk("full_contiguous", starts[5] - starts[0], 5 * FRAME);
        starts.delete();

        // Reset during bit 3 of 0xC3 with two bytes queued
        mon_en = 1'b0;
        push_range(12, 14, 1'b0);
        wait_cyc(acc[12] + 1 + 4 * B + B / 2);
        chk("mid_bit3", tx, 0);
        chk("mid_level", level, 2);
        rst = 1'b1;
        #1;
        chk("mid_rst_tx", tx, 1);
        chk("mid_rst_level", level, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", ready, 1);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (3 * FRAME) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        chk("post_rst_quiet", bad, 0);
        chk("post_rst_level", level, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
